wide_add_sequencer: RTL and testbench

// - Multi-cycle controller that adds two WIDTH-bit operands through a single

---
 rtl/wide_add_sequencer.sv | 123 ++++++++++++
 tb/tb_wide_add_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wide_add_sequencer.sv
// Multi-cycle WIDTH-bit adder built from one shared CHUNK-bit slice, LSB slice first; ADD_SEQ_SUB_EN adds a subtract mode.
// Latency: out_valid rises NCHUNK edges after accept; one job in flight, in_ready only in IDLE.
// Backpressure: a finished result is held in DONE until out_ready; new operands wait until IDLE.
module wide_add_sequencer #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef ADD_SEQ_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                         state;
    logic [IDXW-1:0]                idx;
    logic                           carry;
    logic [NCHUNK-1:0][CHUNK-1:0]   a_q;
    logic [NCHUNK-1:0][CHUNK-1:0]   b_q;
    logic [NCHUNK-1:0][CHUNK-1:0]   sum_q;
`ifdef ADD_SEQ_SUB_EN
    logic                           sub_q;
`endif

    logic [CHUNK-1:0] op_a;
    logic [CHUNK-1:0] op_b;
    logic [CHUNK:0]   slice;

    assign in_ready = (state == IDLE);
    assign sum      = sum_q;

    // The single shared slice; the carry bit is kept in full so it can ripple to the next cycle.
    always_comb begin
        op_a = a_q[idx];
        op_b = b_q[idx];
`ifdef ADD_SEQ_SUB_EN
        if (sub_q) begin
            op_b = ~b_q[idx];
        end
`endif
        slice = {1'b0, op_a} + {1'b0, op_b} + {{CHUNK{1'b0}}, carry};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            carry     <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            sum_q     <= '0;
            cout      <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
`ifdef ADD_SEQ_SUB_EN
            sub_q     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= a;
                        b_q   <= b;
                        idx   <= '0;
                        sum_q <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
`ifdef ADD_SEQ_SUB_EN
                        sub_q <= sub;
                        // Two's complement subtract: a + ~b + 1, so cin is overridden.
                        carry <= sub ? 1'b1 : cin;
`else
                        carry <= cin;
`endif
                    end
                end
                RUN: begin
                    sum_q[idx] <= slice[CHUNK-1:0];
                    carry      <= slice[CHUNK];
                    idx        <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        cout      <= slice[CHUNK];
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Directed bench for wide_add_sequencer: vector table plus reset, backpressure and abort sequences.
module tb_wide_add_sequencer;

    localparam int WIDTH = 64;
    localparam int CHUNK = 16;
    localparam int LAT   = WIDTH / CHUNK;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic             sub;
        logic [WIDTH-1:0] exp_sum;
        logic             exp_cout;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             cin = 1'b0;
`ifdef ADD_SEQ_SUB_EN
    logic             sub = 1'b0;
`endif
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    wide_add_sequencer #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef ADD_SEQ_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mkvec(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                                   input logic vcin, input logic vsub,
                                   input logic [WIDTH-1:0] vsum, input logic vcout);
        vec_t v;
        v.a = va; v.b = vb; v.cin = vcin; v.sub = vsub;
        v.exp_sum = vsum; v.exp_cout = vcout;
        return v;
    endfunction

    task automatic drive_ops(input vec_t v);
        a   = v.a;
        b   = v.b;
        cin = v.cin;
`ifdef ADD_SEQ_SUB_EN
        sub = v.sub;
`endif
    endtask

    // Presents a job, returns #1 after the accept edge with operands scrambled.
    task automatic start_job(input vec_t v);
        int wait_cyc = 0;
        @(negedge clk);
        while (!in_ready && wait_cyc < 20) begin
            @(negedge clk);
            wait_cyc++;
        end
        if (!in_ready) check("in_ready_timeout", {63'd0, in_ready}, 64'd1);
        drive_ops(v);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a   = ~v.a;
        b   = ~v.b;
        cin = ~v.cin;
        check("busy_after_accept", {63'd0, busy}, 64'd1);
    endtask

    // Counts edges from the current point until out_valid is seen.
    task automatic wait_result(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("out_valid_after_consume", {63'd0, out_valid}, 64'd0);
        check("in_ready_after_consume", {63'd0, in_ready}, 64'd1);
    endtask

    vec_t vecs[$];
    vec_t v_bp;
    vec_t v_bp2;
    int   lat;
    bit   saw_valid;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs.push_back(mkvec(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1));
        vecs.push_back(mkvec(64'h0001_0002_0003_0004, 64'h0010_0020_0030_0040, 1'b1, 1'b0,
                             64'h0011_0022_0033_0045, 1'b0));
        vecs.push_back(mkvec(64'h0, 64'h0, 1'b1, 1'b0, 64'h1, 1'b0));
        vecs.push_back(mkvec(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0,
                             64'hFFFF_FFFF_FFFF_FFFF, 1'b1));
        vecs.push_back(mkvec(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'h0, 1'b1));
        vecs.push_back(mkvec(64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0, 1'b0,
                             64'h0001_0000_0001_0000, 1'b0));
        vecs.push_back(mkvec(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0, 1'b0,
                             64'h2345_6789_ABCD_F001, 1'b0));
`ifdef ADD_SEQ_SUB_EN
        vecs.push_back(mkvec(64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0));
        vecs.push_back(mkvec(64'd7, 64'd5, 1'b0, 1'b1, 64'd2, 1'b1));
        vecs.push_back(mkvec(64'd7, 64'd5, 1'b1, 1'b1, 64'd2, 1'b1));
        vecs.push_back(mkvec(64'd9, 64'd9, 1'b0, 1'b1, 64'd0, 1'b1));
`endif

        // Reset state
        #12;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_sum", sum, 64'd0);
        check("rst_cout", {63'd0, cout}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_release_in_ready", {63'd0, in_ready}, 64'd1);

        // Table-driven jobs
        foreach (vecs[i]) begin
            start_job(vecs[i]);
            check("in_ready_while_run", {63'd0, in_ready}, 64'd0);
            wait_result(lat);
            check("latency", 64'(lat), 64'(LAT));
            check("sum", sum, vecs[i].exp_sum);
            check("cout", {63'd0, cout}, {63'd0, vecs[i].exp_cout});
            consume();
        end

        // Mid-cycle reset while a result is waiting
        start_job(vecs[1]);
        wait_result(lat);
        check("pre_rst_out_valid", {63'd0, out_valid}, 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        check("midrst_sum", sum, 64'd0);
        check("midrst_cout", {63'd0, cout}, 64'd0);
        check("midrst_busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_in_ready", {63'd0, in_ready}, 64'd1);

        // Backpressure: hold the result, offer a new job that must wait
        v_bp  = vecs[6];
        v_bp2 = vecs[5];
        start_job(v_bp);
        wait_result(lat);
        check("bp_latency", 64'(lat), 64'(LAT));
        drive_ops(v_bp2);
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check("bp_out_valid", {63'd0, out_valid}, 64'd1);
            check("bp_sum", sum, v_bp.exp_sum);
            check("bp_cout", {63'd0, cout}, {63'd0, v_bp.exp_cout});
            check("bp_in_ready", {63'd0, in_ready}, 64'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp_consume_out_valid", {63'd0, out_valid}, 64'd0);
        check("bp_consume_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        check("bp_next_accepted_busy", {63'd0, busy}, 64'd1);
        wait_result(lat);
        check("bp_next_latency", 64'(lat), 64'(LAT));
        check("bp_next_sum", sum, v_bp2.exp_sum);
        check("bp_next_cout", {63'd0, cout}, {63'd0, v_bp2.exp_cout});
        consume();

        // Abort after two RUN cycles
        start_job(vecs[6]);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("abort_partial_sum", sum, 64'h0000_0000_ABCD_F001);
        rst = 1'b1;
        #2;
        check("abort_sum", sum, 64'd0);
        check("abort_out_valid", {63'd0, out_valid}, 64'd0);
        check("abort_busy", {63'd0, busy}, 64'd0);
        #2;
        rst = 1'b0;
        saw_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) saw_valid = 1'b1;
        end
        check("abort_no_out_valid", {63'd0, saw_valid}, 64'd0);
        check("abort_in_ready", {63'd0, in_ready}, 64'd1);
        start_job(vecs[6]);
        wait_result(lat);
        check("abort_next_latency", 64'(lat), 64'(LAT));
        check("abort_next_sum", sum, vecs[6].exp_sum);
        check("abort_next_cout", {63'd0, cout}, {63'd0, vecs[6].exp_cout});
        consume();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
